// File: rtl/wb_write_arb.sv
// wb_write_arb: merges ALU and load results into an ordered queue that drains one register-file write per cycle.
// Optional forwarding lookup over queued and output-stage writes is enabled by defining WB_BYPASS_EN.
module wb_write_arb #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       alu_valid,
    input  logic [4:0]                 alu_rd,
    input  logic [31:0]                alu_data,
    output logic                       alu_ready,
    input  logic                       mem_valid,
    input  logic [4:0]                 mem_rd,
    input  logic [31:0]                mem_data,
    output logic                       mem_ready,
    output logic [4:0]                 rd,
    output logic [31:0]                rd_data,
    output logic                       RegWrite,
`ifdef WB_BYPASS_EN
    input  logic [4:0]                 rs1,
    input  logic [4:0]                 rs2,
    output logic                       rs1_hit,
    output logic                       rs2_hit,
    output logic [31:0]                rs1_fwd,
    output logic [31:0]                rs2_fwd,
`endif
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    r_q_rd   [DEPTH];
    logic [31:0]   r_q_data [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_we;
    logic [4:0]    r_rd;
    logic [31:0]   r_rd_data;

    logic [CW-1:0] w_free;
    logic [CW-1:0] w_count_nxt;
    logic          w_alu_ready;
    logic          w_mem_ready;
    logic          w_alu_en;
    logic          w_mem_en;
    logic          w_pop;
    logic [AW-1:0] w_mem_ptr;

    // Space is judged on the registered count only; a same-cycle pop never frees a slot early.
    always_comb begin
        w_free      = CW'(DEPTH) - r_count;
        w_alu_ready = w_free >= CW'(1);
        w_mem_ready = alu_valid ? (w_free >= CW'(2)) : w_alu_ready;
        w_alu_en    = alu_valid && w_alu_ready && (alu_rd != 5'd0);
        w_mem_en    = mem_valid && w_mem_ready && (mem_rd != 5'd0);
        w_pop       = r_count != '0;
        w_mem_ptr   = r_wptr + AW'(w_alu_en);
        w_count_nxt = r_count + CW'(w_alu_en) + CW'(w_mem_en) - CW'(w_pop);
    end

    always_ff @(posedge clk) begin
        if (w_alu_en) begin
            r_q_rd[r_wptr]   <= alu_rd;
            r_q_data[r_wptr] <= alu_data;
        end
        if (w_mem_en) begin
            r_q_rd[w_mem_ptr]   <= mem_rd;
            r_q_data[w_mem_ptr] <= mem_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_we      <= 1'b0;
            r_rd      <= '0;
            r_rd_data <= '0;
        end else begin
            r_wptr  <= r_wptr + AW'(w_alu_en) + AW'(w_mem_en);
            r_count <= w_count_nxt;
            r_we    <= w_pop;
            if (w_pop) begin
                r_rptr    <= r_rptr + AW'(1);
                r_rd      <= r_q_rd[r_rptr];
                r_rd_data <= r_q_data[r_rptr];
            end
        end
    end

    assign alu_ready = w_alu_ready;
    assign mem_ready = w_mem_ready;
    assign rd        = r_rd;
    assign rd_data   = r_rd_data;
    assign RegWrite  = r_we;
    assign count     = r_count;

`ifdef WB_BYPASS_EN
    // Oldest candidate is the output stage, then queue head to tail; later matches override earlier ones.
    always_comb begin
        rs1_hit = r_we && (rs1 != 5'd0) && (r_rd == rs1);
        rs2_hit = r_we && (rs2 != 5'd0) && (r_rd == rs2);
        rs1_fwd = rs1_hit ? r_rd_data : '0;
        rs2_fwd = rs2_hit ? r_rd_data : '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < r_count) && (rs1 != 5'd0) && (r_q_rd[r_rptr + AW'(i)] == rs1)) begin
                rs1_hit = 1'b1;
                rs1_fwd = r_q_data[r_rptr + AW'(i)];
            end
            if ((CW'(i) < r_count) && (rs2 != 5'd0) && (r_q_rd[r_rptr + AW'(i)] == rs2)) begin
                rs2_hit = 1'b1;
                rs2_fwd = r_q_data[r_rptr + AW'(i)];
            end
        end
    end
`endif
endmodule

// File: tb/tb_wb_write_arb.sv
// tb_wb_write_arb: queue-model scoreboard checked every cycle plus directed literal expectations.
module tb_wb_write_arb;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        alu_valid, mem_valid;
    logic [4:0]  alu_rd, mem_rd;
    logic [31:0] alu_data, mem_data;
    logic        alu_ready, mem_ready, RegWrite;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic [2:0]  count;
    logic        d2_alu_ready, d2_mem_ready, d2_RegWrite;
    logic [4:0]  d2_rd;
    logic [31:0] d2_rd_data;
    logic [1:0]  d2_count;
`ifdef WB_BYPASS_EN
    logic [4:0]  rs1 = 5'd0, rs2 = 5'd0;
    logic        rs1_hit, rs2_hit, d2_rs1_hit, d2_rs2_hit;
    logic [31:0] rs1_fwd, rs2_fwd, d2_rs1_fwd, d2_rs2_fwd;
`endif

    wb_write_arb #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .rd(rd), .rd_data(rd_data), .RegWrite(RegWrite),
`ifdef WB_BYPASS_EN
        .rs1(rs1), .rs2(rs2), .rs1_hit(rs1_hit), .rs2_hit(rs2_hit), .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd),
`endif
        .count(count)
    );

    wb_write_arb #(.DEPTH(2)) dut2 (
        .clk(clk), .reset_n(reset_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(d2_alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(d2_mem_ready),
        .rd(d2_rd), .rd_data(d2_rd_data), .RegWrite(d2_RegWrite),
`ifdef WB_BYPASS_EN
        .rs1(rs1), .rs2(rs2), .rs1_hit(d2_rs1_hit), .rs2_hit(d2_rs2_hit), .rs1_fwd(d2_rs1_fwd), .rs2_fwd(d2_rs2_fwd),
`endif
        .count(d2_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: an ordered list of pending writes plus the last write presented.
    logic [4:0]  q_rd[$];
    logic [31:0] q_data[$];
    logic        m_we = 1'b0;
    logic [4:0]  m_rd = 5'd0;
    logic [31:0] m_data = 32'd0;

    task automatic model_clear();
        q_rd.delete();
        q_data.delete();
        m_we = 1'b0;
        m_rd = 5'd0;
        m_data = 32'd0;
    endtask

    always @(negedge reset_n) model_clear();

    always @(posedge clk) begin : model
        int free;
        bit ar, mr;
        if (!reset_n) model_clear();
        else begin
            free = DEPTH - q_rd.size();
            ar = free >= 1;
            mr = alu_valid ? free >= 2 : free >= 1;
            if (q_rd.size() > 0) begin
                m_we = 1'b1;
                m_rd = q_rd.pop_front();
                m_data = q_data.pop_front();
            end else m_we = 1'b0;
            if (alu_valid && ar && alu_rd != 0) begin
                q_rd.push_back(alu_rd);
                q_data.push_back(alu_data);
            end
            if (mem_valid && mr && mem_rd != 0) begin
                q_rd.push_back(mem_rd);
                q_data.push_back(mem_data);
            end
        end
    end

    always @(negedge clk) begin : cmp
        int free;
        free = DEPTH - q_rd.size();
        chk("count", 32'(count), 32'(q_rd.size()));
        chk("alu_ready", 32'(alu_ready), 32'(free >= 1));
        chk("mem_ready", 32'(mem_ready), 32'(alu_valid ? free >= 2 : free >= 1));
        chk("RegWrite", 32'(RegWrite), 32'(m_we));
        chk("rd", 32'(rd), 32'(m_rd));
        chk("rd_data", rd_data, m_data);
`ifdef WB_BYPASS_EN
        begin
            bit h1, h2;
            logic [31:0] f1, f2;
            h1 = m_we && rs1 != 0 && m_rd == rs1;
            h2 = m_we && rs2 != 0 && m_rd == rs2;
            f1 = m_data;
            f2 = m_data;
            foreach (q_rd[i]) begin
                if (rs1 != 0 && q_rd[i] == rs1) begin h1 = 1; f1 = q_data[i]; end
                if (rs2 != 0 && q_rd[i] == rs2) begin h2 = 1; f2 = q_data[i]; end
            end
            chk("rs1_hit", 32'(rs1_hit), 32'(h1));
            chk("rs2_hit", 32'(rs2_hit), 32'(h2));
            if (h1) chk("rs1_fwd", rs1_fwd, f1);
            if (h2) chk("rs2_fwd", rs2_fwd, f2);
        end
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                         input bit mv, input logic [4:0] mr, input logic [31:0] md);
        alu_valid = av; alu_rd = ar; alu_data = ad;
        mem_valid = mv; mem_rd = mr; mem_data = md;
    endtask

    task automatic idle();
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    initial begin
        idle();
        repeat (2) tick();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_RegWrite", 32'(RegWrite), 32'd0);
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_alu_ready", 32'(alu_ready), 32'd1);
        chk("rst_mem_ready", 32'(mem_ready), 32'd1);
        reset_n = 1'b1;
        tick();

        // Fill: dual transfers; the DEPTH=2 instance becomes full after one.
        drive(1, 5'd1, 32'h11, 1, 5'd2, 32'h22);
        chk("fill_empty_mem_ready", 32'(mem_ready), 32'd1);
        tick();
        chk("d2_full_count", 32'(d2_count), 32'd2);
        chk("d2_full_alu_ready", 32'(d2_alu_ready), 32'd0);
        chk("d2_full_mem_ready", 32'(d2_mem_ready), 32'd0);
        chk("fill_count2", 32'(count), 32'd2);
        drive(1, 5'd3, 32'h33, 1, 5'd4, 32'h44);
        tick();
        chk("fill_count3", 32'(count), 32'd3);
        chk("fill3_alu_ready", 32'(alu_ready), 32'd1);
        chk("fill3_mem_ready", 32'(mem_ready), 32'd0);
        chk("fill_first_rd", 32'(rd), 32'd1);
        chk("fill_first_data", rd_data, 32'h11);
        tick();
        chk("fill_hold_count3", 32'(count), 32'd3);
        chk("fill_second_data", rd_data, 32'h22);
        idle();
        repeat (5) tick();
        chk("drained_count", 32'(count), 32'd0);

        // Single ALU write latency and one-cycle pulse.
        drive(1, 5'd5, 32'h1234, 0, 5'd0, 32'd0);
        tick();
        idle();
        chk("single_count", 32'(count), 32'd1);
        chk("single_no_write_yet", 32'(RegWrite), 32'd0);
        tick();
        chk("single_RegWrite", 32'(RegWrite), 32'd1);
        chk("single_rd", 32'(rd), 32'd5);
        chk("single_rd_data", rd_data, 32'h1234);
        tick();
        chk("single_pulse_end", 32'(RegWrite), 32'd0);
        chk("single_hold_data", rd_data, 32'h1234);

        // Same rd on both ports: ALU first, no coalescing.
        drive(1, 5'd3, 32'hA, 1, 5'd3, 32'hB);
        tick();
        idle();
        tick();
        chk("order_first_rd", 32'(rd), 32'd3);
        chk("order_first_data", rd_data, 32'hA);
        tick();
        chk("order_second_we", 32'(RegWrite), 32'd1);
        chk("order_second_data", rd_data, 32'hB);
        tick();
        chk("order_done", 32'(RegWrite), 32'd0);

        // rd == 0 is accepted and dropped.
        drive(1, 5'd0, 32'hFFFF, 0, 5'd0, 32'd0);
        #1 chk("x0_alu_ready", 32'(alu_ready), 32'd1);
        tick();
        idle();
        chk("x0_count", 32'(count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("x0_no_write", 32'(RegWrite), 32'd0);
        end

        // Mixed patterns, scored by the model only.
        for (int i = 0; i < 24; i++) begin
            drive((i % 3) != 2, 5'((i * 5) % 8), 32'h100 + 32'(i),
                  (i % 4) != 0, 5'((i * 3) % 7), 32'h200 + 32'(i));
            tick();
        end
        idle();
        repeat (6) tick();

        // Asynchronous reset with entries queued.
        drive(1, 5'd8, 32'h80, 1, 5'd9, 32'h90);
        tick();
        drive(1, 5'd10, 32'hA0, 1, 5'd11, 32'hB0);
        tick();
        idle();
        chk("pre_reset_count", 32'(count), 32'd3);
        chk("pre_reset_we", 32'(RegWrite), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_count", 32'(count), 32'd0);
        chk("async_RegWrite", 32'(RegWrite), 32'd0);
        chk("async_rd", 32'(rd), 32'd0);
        chk("async_rd_data", rd_data, 32'd0);
        drive(1, 5'd12, 32'hC0, 1, 5'd13, 32'hD0);
        #1 chk("rst_ready_high", 32'(alu_ready & mem_ready), 32'd1);
        repeat (2) tick();
        chk("rst_not_recorded", 32'(count), 32'd0);
        idle();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_reset_no_write", 32'(RegWrite), 32'd0);
        end

`ifdef WB_BYPASS_EN
        drive(1, 5'd7, 32'h1, 1, 5'd7, 32'h2);
        tick();
        idle();
        rs1 = 5'd7;
        rs2 = 5'd0;
        #1;
        chk("byp_rs1_hit", 32'(rs1_hit), 32'd1);
        chk("byp_rs1_fwd", rs1_fwd, 32'h2);
        chk("byp_rs2_hit", 32'(rs2_hit), 32'd0);
        tick();
        chk("byp_mixed_fwd", rs1_fwd, 32'h2);
        tick();
        chk("byp_stage_hit", 32'(rs1_hit), 32'd1);
        chk("byp_stage_fwd", rs1_fwd, 32'h2);
        tick();
        chk("byp_gone", 32'(rs1_hit), 32'd0);
        rs1 = 5'd0;
`endif

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
